// File: rtl/wdg_rst_gen_pkg.sv
// wdg_rst_gen_pkg: FSM state type, cause bit indices and fixed timing constants for wdg_rst_gen
package wdg_rst_gen_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;
  localparam int CAUSE_WDG = 0;
  localparam int CAUSE_EXT = 1;
  localparam int CAUSE_SW = 2;
  localparam int CAUSE_POR = 3;
  localparam int MIN_HOLD = 2;
  localparam int COOLDOWN_CYC = 4;
  localparam int RST_CNT_W = 8;
endpackage

// File: rtl/wdg_rst_gen_if.sv
// wdg_rst_gen_if: reset request inputs and reset/status outputs of wdg_rst_gen
interface wdg_rst_gen_if
  import wdg_rst_gen_pkg::*;
#(
  parameter int HOLD_WIDTH = 8
);
  logic                  wdg_rst_i;
  logic                  ext_rst_req_i;
  logic                  sw_rst_req_i;
  logic [HOLD_WIDTH-1:0] hold_cycles_i;
  logic                  cause_clr_i;
  logic                  sys_rst_n_o;
  logic                  rst_busy_o;
  logic [3:0]            cause_o;
  logic [RST_CNT_W-1:0]  rst_cnt_o;
  modport master (
    output wdg_rst_i, ext_rst_req_i, sw_rst_req_i, hold_cycles_i, cause_clr_i,
    input  sys_rst_n_o, rst_busy_o, cause_o, rst_cnt_o
  );
  modport slave (
    input  wdg_rst_i, ext_rst_req_i, sw_rst_req_i, hold_cycles_i, cause_clr_i,
    output sys_rst_n_o, rst_busy_o, cause_o, rst_cnt_o
  );
endinterface

// File: rtl/cdc_sync.sv
// cdc_sync: multi-flop synchroniser for asynchronous level inputs
module cdc_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  // shift the input through the flop chain
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/dffer.sv
// dffer: register with enable and asynchronous active-low reset to RST_VAL
module dffer #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  // load on enable
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
  end
endmodule

// File: rtl/dfferc.sv
// dfferc: register with enable, synchronous clear (priority) and asynchronous active-low reset
module dfferc #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  // clear beats load
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_o <= RST_VAL;
    else if (clr_i) q_o <= '0;
    else if (en_i) q_o <= d_i;
  end
endmodule

// File: rtl/wdg_rst_gen.sv
// wdg_rst_gen: stretched registered system reset with cooldown and sticky cause/count; WDG_RST_GEN_EXT_EN enables the external pin
module wdg_rst_gen
  import wdg_rst_gen_pkg::*;
#(
  parameter int HOLD_WIDTH = 8,
  parameter int POR_HOLD = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk_i,
  input logic          rst_n_i,
  wdg_rst_gen_if.slave bus
);
  localparam logic [HOLD_WIDTH-1:0] MIN_H = HOLD_WIDTH'(MIN_HOLD);
  localparam logic [HOLD_WIDTH-1:0] POR_H = HOLD_WIDTH'((POR_HOLD < MIN_HOLD) ? MIN_HOLD : POR_HOLD);
  localparam logic [HOLD_WIDTH-1:0] ONE = HOLD_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0] COOL_LAST = HOLD_WIDTH'(COOLDOWN_CYC - 1);
  state_e state_q, state_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_ld, cnt_q;
  logic cnt_last, enter, cnt_clr, cnt_en;
  logic ext_sync, sw_now, req;
  logic sw_pend_q, sw_pend_d;
  logic [3:0] src, cause_q, cause_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic sys_rst_n_q, sys_rst_n_d, rst_busy_q, rst_busy_d;
`ifdef WDG_RST_GEN_EXT_EN
  cdc_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_ext_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (bus.ext_rst_req_i),
    .q_o    (ext_sync)
  );
`else
  logic unused_ext;
  assign unused_ext = bus.ext_rst_req_i & (SYNC_STAGES != 0);
  assign ext_sync = 1'b0;
`endif
  assign sw_now = sw_pend_q | bus.sw_rst_req_i;
  assign src = {1'b0, sw_now, ext_sync, bus.wdg_rst_i};
  assign req = |src;
  assign hold_ld = (bus.hold_cycles_i < MIN_H) ? MIN_H : bus.hold_cycles_i;
  assign cnt_last = (state_q == ST_COOLDOWN) ? (cnt_q == COOL_LAST) : (cnt_q == hold_q - ONE);
  dffer #(.WIDTH(HOLD_WIDTH), .RST_VAL(POR_H)) u_hold (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (enter),
    .d_i    (hold_ld),
    .q_o    (hold_q)
  );
  dfferc #(.WIDTH(HOLD_WIDTH), .RST_VAL('0)) u_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .d_i    (cnt_q + ONE),
    .q_o    (cnt_q)
  );
  // next state, counter control, sticky status and next output values
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (req ? ST_ASSERT : ST_IDLE) :
              (state_q == ST_ASSERT) ? ((cnt_last && !req) ? ST_COOLDOWN : ST_ASSERT) :
              (state_q == ST_COOLDOWN) ? (cnt_last ? ST_IDLE : ST_COOLDOWN) : ST_ASSERT;
    enter = (state_q == ST_IDLE) && req;
    cnt_clr = enter || ((state_q == ST_ASSERT) && (state_d == ST_COOLDOWN));
    cnt_en = (state_q != ST_IDLE) && !cnt_last;
    sw_pend_d = (state_d != ST_ASSERT) && sw_now;
    cause_d = (state_q == ST_COOLDOWN) ? cause_q :
              (req || state_q == ST_ASSERT) ? (cause_q | src) :
              bus.cause_clr_i ? 4'b0000 : cause_q;
    rst_cnt_d = (enter && rst_cnt_q != '1) ? rst_cnt_q + RST_CNT_W'(1) : rst_cnt_q;
    sys_rst_n_d = state_q != ST_ASSERT;
    rst_busy_d = state_q != ST_IDLE;
  end
  // state and output registers; power-on reset starts a POR_HOLD reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ASSERT;
      sw_pend_q <= 1'b0;
      cause_q <= 4'b1000;
      rst_cnt_q <= '0;
      sys_rst_n_q <= 1'b0;
      rst_busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sw_pend_q <= sw_pend_d;
      cause_q <= cause_d;
      rst_cnt_q <= rst_cnt_d;
      sys_rst_n_q <= sys_rst_n_d;
      rst_busy_q <= rst_busy_d;
    end
  end
  assign bus.sys_rst_n_o = sys_rst_n_q;
  assign bus.rst_busy_o = rst_busy_q;
  assign bus.cause_o = cause_q;
  assign bus.rst_cnt_o = rst_cnt_q;
endmodule

// File: tb/tb_wdg_rst_gen.sv
// tb_wdg_rst_gen: directed and random stimulus checked against a behavioural reset-generator model
module tb_wdg_rst_gen;
  localparam int SYNC = 2;
  localparam int PORH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  wdg_rst_gen_if #(.HOLD_WIDTH(8)) bus ();
  wdg_rst_gen #(.HOLD_WIDTH(8), .POR_HOLD(PORH), .SYNC_STAGES(SYNC)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  bit m_in, m_swp, m_n, m_busy, m_ext_s, m_sw_e, m_r;
  bit [SYNC-1:0] m_ext;
  int m_min, m_cool, m_cnt;
  logic [3:0] m_cause, m_src;
  // reference: minimum-hold and cooldown countdowns, outputs one cycle behind the phase
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in = 1; m_min = PORH; m_cool = 0; m_swp = 0; m_ext = '0;
      m_cause = 4'b1000; m_cnt = 0; m_n = 0; m_busy = 1;
    end else begin
`ifdef WDG_RST_GEN_EXT_EN
      m_ext_s = m_ext[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_ext[i] = m_ext[i-1];
      m_ext[0] = bus.ext_rst_req_i;
`else
      m_ext_s = 0;
`endif
      m_sw_e = m_swp | bus.sw_rst_req_i;
      m_src = {1'b0, m_sw_e, m_ext_s, bus.wdg_rst_i};
      m_r = |m_src;
      m_n = !m_in;
      m_busy = m_in || m_cool > 0;
      if (m_in) begin
        m_cause |= m_src;
        m_swp = 0;
        if (m_min > 1) m_min--;
        else if (!m_r) begin m_in = 0; m_cool = 4; end
      end else if (m_cool > 0) begin
        m_cool--;
        m_swp = m_sw_e;
      end else if (m_r) begin
        m_in = 1;
        m_min = (bus.hold_cycles_i < 2) ? 2 : int'(bus.hold_cycles_i);
        m_cause |= m_src;
        if (m_cnt < 255) m_cnt++;
        m_swp = 0;
      end else begin
        if (bus.cause_clr_i) m_cause = 4'b0000;
        m_swp = 0;
      end
    end
  end
  // every cycle the DUT outputs must match the model
  always @(posedge clk) begin
    #1;
    check("sys_rst_n", bus.sys_rst_n_o, m_n);
    check("rst_busy", bus.rst_busy_o, m_busy);
    check("cause", bus.cause_o, m_cause);
    check("rst_cnt", bus.rst_cnt_o, m_cnt);
  end
  int run = 0, last_low = 0, tail = 0, last_tail = 0, n_rise = 0;
  // measure length of each low pulse and the busy tail after it
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      run = 0; tail = 0;
    end else if (!bus.sys_rst_n_o) begin
      run++; tail = 0;
    end else begin
      if (run > 0) begin last_low = run; n_rise++; run = 0; end
      if (bus.rst_busy_o) tail++;
      else if (tail > 0) begin last_tail = tail; tail = 0; end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_idle();
    tick();
    for (int i = 0; i < 400 && bus.rst_busy_o; i++) tick();
    check("idle_wait", bus.rst_busy_o, 0);
  endtask
  task automatic wait_sys(input logic v);
    for (int i = 0; i < 100 && bus.sys_rst_n_o !== v; i++) tick();
    check("sys_wait", bus.sys_rst_n_o, v);
  endtask
  task automatic pulse_wdg();
    bus.wdg_rst_i = 1; tick(); bus.wdg_rst_i = 0;
  endtask
  task automatic pulse_sw();
    bus.sw_rst_req_i = 1; tick(); bus.sw_rst_req_i = 0;
  endtask
  logic [3:0] ext_bit;
  int n0;
  initial begin
`ifdef WDG_RST_GEN_EXT_EN
    ext_bit = 4'b0010;
`else
    ext_bit = 4'b0000;
`endif
    bus.wdg_rst_i = 0; bus.ext_rst_req_i = 0; bus.sw_rst_req_i = 0;
    bus.cause_clr_i = 0; bus.hold_cycles_i = 8'd7;
    repeat (3) tick();
    rst_n = 1;
    wait_idle();
    check("por_low", last_low, 16);
    check("por_tail", last_tail, 4);
    check("por_cause", bus.cause_o, 4'b1000);
    check("por_cnt", bus.rst_cnt_o, 0);
    bus.hold_cycles_i = 8'd5;
    pulse_wdg();
    wait_idle();
    check("wdg5_low", last_low, 5);
    check("wdg5_cause", bus.cause_o, 4'b1001);
    check("wdg5_cnt", bus.rst_cnt_o, 1);
    bus.cause_clr_i = 1; tick(); bus.cause_clr_i = 0;
    check("clr_idle", bus.cause_o, 4'b0000);
    bus.hold_cycles_i = 8'd0;
    pulse_sw();
    wait_idle();
    check("sw_min_low", last_low, 2);
    check("sw_cause", bus.cause_o, 4'b0100);
    check("sw_cnt", bus.rst_cnt_o, 2);
    bus.hold_cycles_i = 8'd3;
    bus.wdg_rst_i = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) bus.hold_cycles_i = 8'd200;
      if (i == 4) bus.ext_rst_req_i = 1;
      if (i == 6) bus.ext_rst_req_i = 0;
      tick();
    end
    bus.wdg_rst_i = 0;
    wait_idle();
    check("long_low", last_low, 10);
    check("long_cnt", bus.rst_cnt_o, 3);
    check("long_cause", bus.cause_o, 4'b0101 | ext_bit);
    bus.hold_cycles_i = 8'd2;
    n0 = n_rise;
    pulse_wdg();
    wait_sys(0);
    wait_sys(1);
    bus.sw_rst_req_i = 1; bus.cause_clr_i = 1;
    tick();
    bus.sw_rst_req_i = 0;
    repeat (5) tick();
    bus.cause_clr_i = 0;
    wait_idle();
    check("cool_rises", n_rise - n0, 2);
    check("cool_cnt", bus.rst_cnt_o, 5);
    check("cool_cause", bus.cause_o, 4'b0101 | ext_bit);
    bus.cause_clr_i = 1; tick(); bus.cause_clr_i = 0;
    check("clr_idle2", bus.cause_o, 4'b0000);
    bus.hold_cycles_i = 8'd50;
    pulse_wdg();
    repeat (5) tick();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    wait_idle();
    check("midrst_low", last_low, 16);
    check("midrst_tail", last_tail, 4);
    check("midrst_cause", bus.cause_o, 4'b1000);
    check("midrst_cnt", bus.rst_cnt_o, 0);
    bus.hold_cycles_i = 8'd4;
    bus.ext_rst_req_i = 1;
    repeat (4) tick();
    bus.ext_rst_req_i = 0;
    repeat (8) tick();
    check("ext_cnt", bus.rst_cnt_o, (ext_bit != 0) ? 1 : 0);
    check("ext_cause", bus.cause_o, 4'b1000 | ext_bit);
    wait_idle();
    bus.hold_cycles_i = 8'd0;
    for (int i = 0; i < 260; i++) begin
      pulse_sw();
      wait_idle();
    end
    check("cnt_sat", bus.rst_cnt_o, 255);
    for (int i = 0; i < 3000; i++) begin
      if (bus.wdg_rst_i) bus.wdg_rst_i = ($urandom_range(0, 2) != 0);
      else bus.wdg_rst_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) bus.ext_rst_req_i = ~bus.ext_rst_req_i;
      bus.sw_rst_req_i = ($urandom_range(0, 9) == 0);
      bus.cause_clr_i = ($urandom_range(0, 4) == 0);
      bus.hold_cycles_i = 8'($urandom_range(0, 12));
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    bus.wdg_rst_i = 0; bus.ext_rst_req_i = 0; bus.sw_rst_req_i = 0;
    bus.cause_clr_i = 0; rst_n = 1;
    repeat (4) tick();
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
